// File: rtl/mem_initiator.sv
// Requester engine for the single-port RAM valid/we/mask/resp interface.
// Handles one byte/half/word load or store at a time, with lane steering, extension and timeout.
module mem_initiator #(
  parameter int ADDRW   = 10,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [ADDRW-1:0] req_addr_i,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [31:0]      req_wdata_i,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_err_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [3:0]       mem_mask_o,
  output logic             mem_we_o,
  output logic             mem_valid_o,
  input  logic [31:0]      mem_data_i,
  input  logic             mem_resp_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [ADDRW-1:0] addr_q;
  logic             we_q;
  logic [3:0]       mask_q;
  logic [31:0]      wdat_q;
  logic             mem_valid_q;
  logic             rsp_valid_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             misaligned;
  logic             timeout_hit;
  logic [3:0]       mask_req;
  logic [31:0]      data_req;
  logic [31:0]      shifted;
  logic [31:0]      load_val;

  assign misaligned = (req_size_i == 2'd3) ||
                      (req_size_i == 2'd1 && req_addr_i[0]) ||
                      (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00);

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    mask_req = 4'b0000;
    data_req = 32'h0;
    if (req_we_i) begin
      case (req_size_i)
        2'd0: begin
          mask_req = 4'b0001 << req_addr_i[1:0];
          data_req = {4{req_wdata_i[7:0]}};
        end
        2'd1: begin
          mask_req = 4'b0011 << req_addr_i[1:0];
          data_req = {2{req_wdata_i[15:0]}};
        end
        2'd2: begin
          mask_req = 4'b1111;
          data_req = req_wdata_i;
        end
        default: begin
          mask_req = 4'b0000;
          data_req = 32'h0;
        end
      endcase
    end
  end

  // Load data is right-aligned by the latched byte offset before extension.
  assign shifted = mem_data_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = mem_data_i;
    case (size_q)
      2'd0:    load_val = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = mem_data_i;
    endcase
    if (we_q) load_val = 32'h0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (misaligned) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (mem_resp_i) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = load_val;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_i) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = load_val;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      mask_q      <= 4'b0000;
      wdat_q      <= 32'h0;
      mem_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_valid_q <= (state_d == ISSUE);
      rsp_valid_q <= (state_d == RESP);
      if (state_q == IDLE && req_valid_i && !misaligned) begin
        addr_q <= req_addr_i;
        we_q   <= req_we_i;
        size_q <= req_size_i;
        uns_q  <= req_unsigned_i;
        mask_q <= mask_req;
        wdat_q <= data_req;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_mask_o  = mask_q;
  assign mem_data_o  = wdat_q;
  assign mem_valid_o = mem_valid_q;

endmodule
